dcache_assoc: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate data cache for the 5-stage pipeline's memory stage.
- Successor to the current direct-mapped cache; uses the same 128-bit line interface to datamem.
- New over the existing cache: configurable ways, sets and line width; per-set round-robin replacement with invalid-way preference; dirty write-back; hit/miss performance counters.

---
 rtl/dcache_pkg.sv | 21 ++
 rtl/dcache_way.sv | 61 ++++++
 rtl/dcache_assoc.sv | 159 +++++++++++++++
 tb/tb_dcache_assoc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM type, address-mode constants and address-split helpers for the associative data cache
package dcache_pkg;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   localparam logic ADDR_MODE_WORD = 1'b0;
   localparam logic ADDR_MODE_BYTE = 1'b1;

   function automatic int off_w(input int line_bits);
      return $clog2(line_bits / 8);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int addr_width, input int sets, input int line_bits);
      return addr_width - idx_w(sets) - off_w(line_bits);
   endfunction

endpackage

// File: rtl/dcache_way.sv
// dcache_way: tag, valid, dirty and line storage for one cache way with combinational hit
module dcache_way
   import dcache_pkg::*;
#(
   parameter int SETS      = 64,
   parameter int LINE_BITS = 128,
   parameter int IW        = idx_w(SETS),
   parameter int TW        = 22
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IW-1:0]        idx,
   input  logic [TW-1:0]        tag,
   input  logic                 st_en,
   input  logic [LINE_BITS-1:0] st_mask,
   input  logic [LINE_BITS-1:0] st_line,
   input  logic                 fill_en,
   input  logic [TW-1:0]        fill_tag,
   input  logic [LINE_BITS-1:0] fill_line,
   output logic                 hit,
   output logic                 vld,
   output logic                 dty,
   output logic [TW-1:0]        vtag,
   output logic [LINE_BITS-1:0] line
);

   logic [SETS-1:0]      valid;
   logic [SETS-1:0]      dirty;
   logic [TW-1:0]        tags [SETS];
   logic [LINE_BITS-1:0] data [SETS];

   assign vld  = valid[idx];
   assign dty  = dirty[idx];
   assign vtag = tags[idx];
   assign line = data[idx];
   assign hit  = vld && vtag == tag;

   // Status bits: reset invalidates, refill installs a clean line, store marks the line dirty
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (fill_en) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (st_en) begin
         dirty[idx] <= 1'b1;
      end
   end

   // Tag and line storage; contents are meaningless until valid, so no reset
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tags[idx] <= fill_tag;
         data[idx] <= fill_line;
      end else if (st_en) begin
         data[idx] <= (data[idx] & ~st_mask) | (st_line & st_mask);
      end
   end

endmodule

// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative write-back write-allocate data cache with round-robin replacement
module dcache_assoc
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int WAYS       = 2,
   parameter int SETS       = 64,
   parameter int LINE_BITS  = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic [ADDR_WIDTH-1:0] data_address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  MemWrite,
   input  logic                  AddrMode,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  WriteEnable,
   output logic [ADDR_WIDTH-1:0] memory_address,
   output logic [LINE_BITS-1:0]  mem_writedata,
   input  logic [LINE_BITS-1:0]  mem_readdata,
   input  logic                  mem_ready,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
);

   localparam int OFF = off_w(LINE_BITS);
   localparam int IW  = idx_w(SETS);
   localparam int TW  = tag_w(ADDR_WIDTH, SETS, LINE_BITS);
   localparam int WW  = WAYS > 1 ? $clog2(WAYS) : 1;
   localparam int WPL = LINE_BITS / DATA_WIDTH;

   state_t               state;
   logic                 idle;
   logic                 miss;
   logic                 hit_any;
   logic                 retry;
   logic                 m_evict;
   logic [IW-1:0]        a_idx;
   logic [IW-1:0]        m_idx;
   logic [IW-1:0]        idx;
   logic [TW-1:0]        a_tag;
   logic [TW-1:0]        m_tag;
   logic [WW-1:0]        h_way;
   logic [WW-1:0]        v_way;
   logic [WW-1:0]        m_way;
   logic [WW-1:0]        rr [SETS];
   logic [WAYS-1:0]      hit;
   logic [WAYS-1:0]      vld;
   logic [WAYS-1:0]      dty;
   logic [TW-1:0]        vtag [WAYS];
   logic [LINE_BITS-1:0] line [WAYS];
   logic [LINE_BITS-1:0] st_mask;
   logic [LINE_BITS-1:0] st_line;
   logic [OFF+2:0]       shift;
   logic [DATA_WIDTH-1:0] wdat;
   logic [DATA_WIDTH-1:0] word;
   logic [7:0]           sel_byte;

   assign a_idx   = data_address[OFF +: IW];
   assign a_tag   = data_address[ADDR_WIDTH-1 -: TW];
   assign idle    = state == IDLE;
   // Once a miss is latched, the arrays are addressed by the latched set, not the live address
   assign idx     = idle ? a_idx : m_idx;
   assign hit_any = |hit;
   assign miss    = idle && req && !hit_any;
   assign stall   = !idle || miss;

   assign shift    = {data_address[OFF-1:2], AddrMode == ADDR_MODE_BYTE ? data_address[1:0] : 2'b00, 3'b000};
   assign wdat     = AddrMode == ADDR_MODE_BYTE ? {DATA_WIDTH/8{write_data[7:0]}} : write_data;
   assign st_line  = {WPL{wdat}};
   assign st_mask  = (AddrMode == ADDR_MODE_WORD ? LINE_BITS'({DATA_WIDTH{1'b1}}) : LINE_BITS'(8'hFF)) << shift;
   assign word     = DATA_WIDTH'(line[h_way] >> {data_address[OFF-1:2], 5'd0});
   assign sel_byte = 8'(word >> {data_address[1:0], 3'd0});
   assign read_data = req && idle && hit_any ? (AddrMode == ADDR_MODE_BYTE ? DATA_WIDTH'(sel_byte) : word) : '0;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      dcache_way #(
         .SETS(SETS),
         .LINE_BITS(LINE_BITS),
         .IW(IW),
         .TW(TW)
      ) u_way (
         .clk,
         .rst,
         .idx,
         .tag(a_tag),
         .st_en(idle && req && MemWrite && hit[w]),
         .st_mask,
         .st_line,
         .fill_en(state == REFILL && mem_ready && m_way == WW'(w)),
         .fill_tag(m_tag),
         .fill_line(mem_readdata),
         .hit(hit[w]),
         .vld(vld[w]),
         .dty(dty[w]),
         .vtag(vtag[w]),
         .line(line[w])
      );
   end

   // Hitting way, and victim: lowest invalid way, otherwise the set's round-robin pointer
   always_comb begin
      h_way = '0;
      v_way = rr[a_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         h_way = hit[w] ? WW'(w) : h_way;
         v_way = !vld[w] ? WW'(w) : v_way;
      end
   end

   // Miss FSM with registered memory-side outputs, replacement pointers and saturating counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         mem_req     <= 1'b0;
         WriteEnable <= 1'b0;
         retry       <= 1'b0;
         hit_count   <= '0;
         miss_count  <= '0;
         for (int s = 0; s < SETS; s++) rr[s] <= '0;
      end else begin
         case (state)
            IDLE: begin
               retry <= 1'b0;
               if (req && hit_any && !retry && hit_count != '1) hit_count <= hit_count + 1'b1;
               if (miss) begin
                  if (miss_count != '1) miss_count <= miss_count + 1'b1;
                  m_idx          <= a_idx;
                  m_tag          <= a_tag;
                  m_way          <= v_way;
                  m_evict        <= vld[v_way];
                  mem_req        <= 1'b1;
                  WriteEnable    <= dty[v_way];
                  memory_address <= {dty[v_way] ? vtag[v_way] : a_tag, a_idx, {OFF{1'b0}}};
                  mem_writedata  <= line[v_way];
                  state          <= dty[v_way] ? WRITEBACK : REFILL;
               end
            end
            WRITEBACK: if (mem_ready) begin
               WriteEnable    <= 1'b0;
               memory_address <= {m_tag, m_idx, {OFF{1'b0}}};
               state          <= REFILL;
            end
            REFILL: if (mem_ready) begin
               mem_req <= 1'b0;
               retry   <= 1'b1;
               state   <= IDLE;
               if (m_evict) rr[m_idx] <= WAYS == 1 ? '0 : m_way + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: randomized and directed checks of dcache_assoc against a line-level reference model
module tb_dcache_assoc;

   localparam int WAYS = 2;
   localparam int SETS = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         req;
   logic [31:0]  data_address;
   logic [31:0]  write_data;
   logic         MemWrite;
   logic         AddrMode;
   logic [31:0]  read_data;
   logic         stall;
   logic         mem_req;
   logic         WriteEnable;
   logic [31:0]  memory_address;
   logic [127:0] mem_writedata;
   logic [127:0] mem_readdata;
   logic         mem_ready;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   dcache_assoc #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .WAYS(WAYS),
      .SETS(SETS),
      .LINE_BITS(128)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .data_address(data_address),
      .write_data(write_data),
      .MemWrite(MemWrite),
      .AddrMode(AddrMode),
      .read_data(read_data),
      .stall(stall),
      .mem_req(mem_req),
      .WriteEnable(WriteEnable),
      .memory_address(memory_address),
      .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata),
      .mem_ready(mem_ready),
      .hit_count(hit_count),
      .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int exp_hit;
   int exp_miss;

   bit           mv   [SETS][WAYS];
   bit           md   [SETS][WAYS];
   logic [21:0]  mt   [SETS][WAYS];
   logic [127:0] mdat [SETS][WAYS];
   int           mrr  [SETS];
   logic [127:0] mem  [logic [31:0]];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) begin
         mrr[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            mv[s][w] = 1'b0;
            md[s][w] = 1'b0;
         end
      end
      exp_hit  = 0;
      exp_miss = 0;
   endtask

   // Hold the current memory transaction for dly cycles, then complete it with mem_ready
   task automatic wait_ready(input int dly, input bit perturb, input logic [31:0] a, input logic [31:0] ea);
      for (int i = 0; i < dly; i++) begin
         if (perturb) data_address = $urandom;
         @(negedge clk);
         chk("hold_req", mem_req, 1'b1);
         chk("hold_stall", stall, 1'b1);
         chk("hold_addr", memory_address, ea);
      end
      data_address = a;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
   endtask

   // One complete CPU access, acting as memory and checking against the model
   task automatic access(input logic [31:0] a, input bit w, input bit b, input logic [31:0] d,
                         input int dly, input bit perturb);
      int s, ws, ln, v;
      logic [21:0]  t;
      logic [31:0]  la, wa, rw;
      logic [127:0] rl;
      s  = int'(a[9:4]);
      t  = a[31:10];
      ws = int'(a[3:2]);
      ln = int'(a[1:0]);
      v  = -1;
      for (int i = 0; i < WAYS; i++) if (mv[s][i] && mt[s][i] == t) v = i;
      req = 1'b1;
      data_address = a;
      MemWrite = w;
      AddrMode = b;
      write_data = d;
      #1;
      if (v < 0) begin
         chk("miss_stall", stall, 1'b1);
         for (int i = WAYS - 1; i >= 0; i--) if (!mv[s][i] && v < 0) v = i;
         for (int i = WAYS - 1; i >= 0; i--) if (!mv[s][i]) v = i;
         if (v < 0) v = mrr[s];
         exp_miss++;
         @(negedge clk);
         la = a & ~32'hF;
         if (mv[s][v] && md[s][v]) begin
            wa = {mt[s][v], 6'(s), 4'h0};
            chk("wb_req", mem_req, 1'b1);
            chk("wb_we", WriteEnable, 1'b1);
            chk("wb_addr", memory_address, wa);
            chk("wb_data", mem_writedata, mdat[s][v]);
            wait_ready(dly, perturb, a, wa);
            mem[wa] = mdat[s][v];
         end
         chk("rf_req", mem_req, 1'b1);
         chk("rf_we", WriteEnable, 1'b0);
         chk("rf_addr", memory_address, la);
         if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
         mem_readdata = mem[la];
         wait_ready(dly, perturb, a, la);
         if (mv[s][v]) mrr[s] = (mrr[s] + 1) % WAYS;
         mv[s][v]   = 1'b1;
         md[s][v]   = 1'b0;
         mt[s][v]   = t;
         mdat[s][v] = mem[la];
         chk("retry_stall", stall, 1'b0);
      end else begin
         chk("hit_stall", stall, 1'b0);
         exp_hit++;
      end
      rl = mdat[s][v];
      rw = rl[ws*32 +: 32];
      if (!w) chk(b ? "load_byte" : "load_word", read_data, b ? (rw >> (ln * 8)) & 32'hFF : rw);
      @(posedge clk);
      if (w) begin
         if (b) mdat[s][v][ws*32 + ln*8 +: 8] = d[7:0];
         else   mdat[s][v][ws*32 +: 32] = d;
         md[s][v] = 1'b1;
      end
      @(negedge clk);
      req = 1'b0;
      MemWrite = 1'b0;
      #1;
      chk("idle_rdata", read_data, 32'h0);
      chk("idle_stall", stall, 1'b0);
      chk("hit_count", hit_count, 32'(exp_hit));
      chk("miss_count", miss_count, 32'(exp_miss));
   endtask

   // Miss into REFILL with memory never answering, then reset mid-transaction
   task automatic reset_mid(input logic [31:0] a);
      req = 1'b1;
      data_address = a;
      MemWrite = 1'b0;
      AddrMode = 1'b0;
      #1;
      chk("rst_miss_stall", stall, 1'b1);
      @(negedge clk);
      chk("rst_refill_req", mem_req, 1'b1);
      chk("rst_refill_we", WriteEnable, 1'b0);
      chk("rst_refill_addr", memory_address, a & ~32'hF);
      @(negedge clk);
      rst = 1'b1;
      req = 1'b0;
      @(negedge clk);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_hits", hit_count, 32'h0);
      chk("rst_misses", miss_count, 32'h0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rst = 1'b1;
      req = 1'b0;
      data_address = '0;
      write_data = '0;
      MemWrite = 1'b0;
      AddrMode = 1'b0;
      mem_readdata = '0;
      mem_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_stall", stall, 1'b0);
      chk("reset_mem_req", mem_req, 1'b0);
      chk("reset_we", WriteEnable, 1'b0);
      chk("reset_hits", hit_count, 32'h0);
      chk("reset_misses", miss_count, 32'h0);
      chk("reset_rdata", read_data, 32'h0);
      mem[32'h100] = {4{32'hDEADBEEF}};
      access(32'h100, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      access(32'h104, 1'b1, 1'b0, 32'h11223344, 0, 1'b0);
      access(32'h104, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      chk("store_load_hits", hit_count, 32'd2);
      access(32'h105, 1'b0, 1'b1, 32'h0, 0, 1'b0);
      access(32'h000, 1'b0, 1'b0, 32'h0, 1, 1'b0);
      access(32'h400, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      access(32'h800, 1'b0, 1'b0, 32'h0, 2, 1'b0);
      access(32'h400, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      access(32'h000, 1'b1, 1'b0, 32'hCAFEF00D, 0, 1'b0);
      access(32'h400, 1'b0, 1'b0, 32'h0, 1, 1'b0);
      access(32'h800, 1'b0, 1'b0, 32'h0, 2, 1'b0);
      chk("dirty_wb_word", mem[32'h000][31:0], 32'hCAFEF00D);
      reset_mid(32'h2340);
      access(32'h2340, 1'b0, 1'b0, 32'h0, 0, 1'b0);
      access(32'h3450, 1'b0, 1'b0, 32'h0, 5, 1'b1);
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = 32'(($urandom_range(0, 5) << 10) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
         access(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
